// File: rtl/smart_code_transmitter.sv
// Serial unlock-code transmitter: shifts a code word out MSB first, one bit per
// bit period, then holds the line low for a guard gap and pulses done.
module smart_code_transmitter #(
   parameter int                  CODE_LEN   = 7,
   parameter logic [CODE_LEN-1:0] CODE_DEF   = 7'b1101011,
   parameter int                  BIT_CYCLES = 1,
   parameter int                  GAP_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                use_def,
   input  logic [CODE_LEN-1:0] code_in,
   input  logic                abort,
   output logic                tx_bit,
   output logic                busy,
   output logic                done
);

   localparam int IDX_W = $clog2(CODE_LEN);
   localparam int CYC_W = $clog2(BIT_CYCLES + 1);
   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      SEND = 2'b01,
      GAP  = 2'b10
   } state_t;

   state_t              state, state_n;
   logic [CODE_LEN-1:0] shreg, shreg_n;
   logic [IDX_W-1:0]    bit_idx, bit_idx_n;
   logic [CYC_W-1:0]    cyc_cnt, cyc_cnt_n;
   logic [GAP_W-1:0]    gap_cnt, gap_cnt_n;
   logic                tx_n, busy_n, done_n;
   logic [CODE_LEN-1:0] load_code;

   assign load_code = use_def ? CODE_DEF : code_in;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         shreg   <= '0;
         bit_idx <= '0;
         cyc_cnt <= '0;
         gap_cnt <= '0;
         tx_bit  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         bit_idx <= bit_idx_n;
         cyc_cnt <= cyc_cnt_n;
         gap_cnt <= gap_cnt_n;
         tx_bit  <= tx_n;
         busy    <= busy_n;
         done    <= done_n;
      end
   end

   // Outputs are computed one cycle ahead so tx_bit/busy/done come straight from flops.
   always_comb begin
      state_n   = state;
      shreg_n   = shreg;
      bit_idx_n = bit_idx;
      cyc_cnt_n = cyc_cnt;
      gap_cnt_n = gap_cnt;
      tx_n      = 1'b0;
      busy_n    = 1'b0;
      done_n    = 1'b0;
      case (state)
         IDLE: begin
            bit_idx_n = '0;
            cyc_cnt_n = '0;
            gap_cnt_n = '0;
            if (start) begin
               state_n = SEND;
               shreg_n = load_code;
               tx_n    = load_code[CODE_LEN-1];
               busy_n  = 1'b1;
            end
         end
         SEND: begin
            if (abort) begin
               state_n   = IDLE;
               bit_idx_n = '0;
               cyc_cnt_n = '0;
            end else begin
               busy_n = 1'b1;
               if (cyc_cnt == CYC_LAST) begin
                  cyc_cnt_n = '0;
                  if (bit_idx == IDX_LAST) begin
                     state_n   = GAP;
                     bit_idx_n = '0;
                     gap_cnt_n = '0;
                  end else begin
                     shreg_n   = shreg << 1;
                     bit_idx_n = bit_idx + 1'b1;
                     tx_n      = shreg[CODE_LEN-2];
                  end
               end else begin
                  cyc_cnt_n = cyc_cnt + 1'b1;
                  tx_n      = shreg[CODE_LEN-1];
               end
            end
         end
         GAP: begin
            if (abort) begin
               state_n   = IDLE;
               gap_cnt_n = '0;
            end else if (gap_cnt == GAP_LAST) begin
               state_n   = IDLE;
               gap_cnt_n = '0;
               done_n    = 1'b1;
            end else begin
               gap_cnt_n = gap_cnt + 1'b1;
               busy_n    = 1'b1;
            end
         end
         default: begin
            state_n   = IDLE;
            shreg_n   = '0;
            bit_idx_n = '0;
            cyc_cnt_n = '0;
            gap_cnt_n = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_smart_code_transmitter.sv
// Directed bench for smart_code_transmitter: default timing instance plus a
// BIT_CYCLES=3 instance; inputs driven and outputs sampled on the falling edge.
module tb_smart_code_transmitter;

   logic       clock = 1'b0;
   logic       reset;
   logic       start_a, start_b;
   logic       use_def;
   logic [6:0] code_in;
   logic       abort;
   logic       tx_a, busy_a, done_a;
   logic       tx_b, busy_b, done_b;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clock = ~clock;

   smart_code_transmitter dut_a (
      .clock(clock), .reset(reset), .start(start_a), .use_def(use_def),
      .code_in(code_in), .abort(abort), .tx_bit(tx_a), .busy(busy_a), .done(done_a)
   );

   smart_code_transmitter #(.BIT_CYCLES(3)) dut_b (
      .clock(clock), .reset(reset), .start(start_b), .use_def(use_def),
      .code_in(code_in), .abort(abort), .tx_bit(tx_b), .busy(busy_b), .done(done_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Set the shared inputs for the coming edge and advance to the next sample point.
   task automatic applyStimulus(input logic st_a, input logic st_b, input logic ud,
                                input logic [6:0] code, input logic ab);
      start_a = st_a;
      start_b = st_b;
      use_def = ud;
      code_in = code;
      abort   = ab;
      @(negedge clock);
   endtask

   // Called in cycle 1 of a dut_a frame; restart_at re-pulses start in that cycle.
   task automatic checkFrameA(input logic [6:0] code, input int restart_at, input string tag);
      for (int c = 1; c <= 10; c++) begin
         if (c <= 7) begin
            checkOutput($sformatf("%s_tx%0d", tag, c), tx_a, code[7-c]);
            checkOutput($sformatf("%s_busy%0d", tag, c), busy_a, 1);
            checkOutput($sformatf("%s_done%0d", tag, c), done_a, 0);
         end else if (c <= 9) begin
            checkOutput($sformatf("%s_gaptx%0d", tag, c), tx_a, 0);
            checkOutput($sformatf("%s_gapbusy%0d", tag, c), busy_a, 1);
            checkOutput($sformatf("%s_gapdone%0d", tag, c), done_a, 0);
         end else begin
            checkOutput($sformatf("%s_done", tag), done_a, 1);
            checkOutput($sformatf("%s_donebusy", tag), busy_a, 0);
            checkOutput($sformatf("%s_donetx", tag), tx_a, 0);
         end
         applyStimulus(c == restart_at, 1'b0, use_def, code_in, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [6:0] def_code;
      logic [6:0] alt_code;
      logic [6:0] b_code;
      int         done_pulses;
      int         busy_cycles;
      def_code = 7'b1101011;
      alt_code = 7'b0011001;
      b_code   = 7'b1010101;

      reset = 1'b1;
      start_a = 1'b0; start_b = 1'b0; use_def = 1'b1; code_in = '0; abort = 1'b0;
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset_tx", tx_a, 0);
      checkOutput("reset_busy", busy_a, 0);
      checkOutput("reset_done", done_a, 0);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      checkOutput("idle_busy", busy_a, 0);

      // Default code frame, then a frame with a stray start at cycle 3.
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      checkFrameA(def_code, -1, "def");
      checkOutput("def_done_pulse", done_a, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      checkFrameA(def_code, 3, "ignore");

      // Start in the done cycle chains straight into an alternate-code frame.
      applyStimulus(1'b0, 1'b0, 1'b0, alt_code, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, alt_code, 1'b0);
      checkFrameA(alt_code, 10, "alt");
      checkFrameA(alt_code, -1, "chain");

      // Abort in cycle 4.
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      for (int c = 1; c <= 3; c++) begin
         checkOutput($sformatf("abort_pre_tx%0d", c), tx_a, def_code[7-c]);
         applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      end
      checkOutput("abort_c4_busy", busy_a, 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b1);
      checkOutput("abort_c5_tx", tx_a, 0);
      checkOutput("abort_c5_busy", busy_a, 0);
      done_pulses = 0;
      for (int c = 5; c <= 12; c++) begin
         if (done_a === 1'b1) done_pulses++;
         applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      end
      checkOutput("abort_no_done", done_pulses, 0);
      checkOutput("abort_idle_busy", busy_a, 0);

      // Abort together with start in IDLE: start wins.
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b1);
      checkFrameA(def_code, -1, "startwins");

      // Asynchronous reset in the middle of cycle 2 of a frame.
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      checkOutput("areset_pre_tx", tx_a, 1);
      checkOutput("areset_pre_busy", busy_a, 1);
      #2 reset = 1'b1;
      #1;
      checkOutput("areset_tx", tx_a, 0);
      checkOutput("areset_busy", busy_a, 0);
      checkOutput("areset_done", done_a, 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 7'h00, 1'b0);
      checkOutput("areset_after_busy", busy_a, 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h00, 1'b0);
      checkFrameA(def_code, -1, "postreset");

      // BIT_CYCLES=3 instance with an external code word.
      applyStimulus(1'b0, 1'b1, 1'b0, b_code, 1'b0);
      done_pulses = 0;
      busy_cycles = 0;
      for (int c = 1; c <= 26; c++) begin
         if (c <= 21)
            checkOutput($sformatf("slow_tx%0d", c), tx_b, b_code[6 - (c - 1) / 3]);
         else if (c <= 23)
            checkOutput($sformatf("slow_gaptx%0d", c), tx_b, 0);
         if (c == 24) checkOutput("slow_done", done_b, 1);
         if (busy_b === 1'b1) busy_cycles++;
         if (done_b === 1'b1) done_pulses++;
         applyStimulus(1'b0, 1'b0, 1'b0, 7'h00, 1'b0);
      end
      checkOutput("slow_busy_cycles", busy_cycles, 23);
      checkOutput("slow_done_count", done_pulses, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
